fifo_stream_reader: RTL

Read side of the median-filter line/pixel FIFOs: pops words from a `sync_fifo_generic` instance, which has fall-through output (`REGOUT=0`), and presents them as a valid/ready pixel stream toward the filter window logic. A 2-entry output buffer decouples downstream back-pressure from `rd_en`, so there is no combinational path from `m_ready` to the FIFO. Column/row counters tag each pixel with start-of-frame and end-of-line markers and flag frame completion.

---
 rtl/median_filter_pkg.sv | 21 ++
 rtl/stream_skid_buf.sv | 53 +++++
 rtl/fifo_stream_reader.sv | 109 ++++++++++
 3 files changed

// File: rtl/median_filter_pkg.sv
// Shared state encodings and sizing helpers for the median-filter stream blocks.
package median_filter_pkg;

   typedef enum logic [1:0] {
      ST_IDLE  = 2'd0,
      ST_RUN   = 2'd1,
      ST_DRAIN = 2'd2
   } state_t;

   localparam int IMG_W_DEF = 640;
   localparam int IMG_H_DEF = 480;

   // Width of a counter that must hold 0..n-1; never narrower than one bit.
   function automatic int cnt_width(input int n);
      return (n <= 2) ? 1 : $clog2(n);
   endfunction

   localparam int COL_W = cnt_width(IMG_W_DEF);
   localparam int ROW_W = cnt_width(IMG_H_DEF);

endpackage

// File: rtl/stream_skid_buf.sv
// Two-entry output buffer between the FIFO pop strobe and the downstream handshake.
module stream_skid_buf #(
   parameter int WIDTH = 8
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             push,
   input  logic [WIDTH-1:0] din,
   input  logic             ready,
   output logic             valid,
   output logic [WIDTH-1:0] dout,
   output logic [1:0]       count
);

   logic [WIDTH-1:0] head;
   logic [WIDTH-1:0] tail;
   logic             pop;

   assign valid = (count != 2'd0);
   assign dout  = head;
   assign pop   = valid && ready;

   // The reader never pushes into a full buffer, so count stays within 0..2.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         head  <= '0;
         tail  <= '0;
         count <= 2'd0;
      end else begin
         case ({push, pop})
            2'b10: begin
               if (count == 2'd0) head <= din;
               else               tail <= din;
               count <= count + 2'd1;
            end
            2'b01: begin
               head  <= tail;
               count <= count - 2'd1;
            end
            2'b11: begin
               if (count == 2'd2) begin
                  head <= tail;
                  tail <= din;
               end else begin
                  head <= din;
               end
            end
            default: ;
         endcase
      end
   end

endmodule

// File: rtl/fifo_stream_reader.sv
// Pops a fall-through FIFO into a valid/ready pixel stream tagged with SOF/EOL.
// Optional starvation counter enabled by defining FIFO_READER_UNDERRUN_CNT_EN.
module fifo_stream_reader
   import median_filter_pkg::*;
#(
   parameter int WIDTH = 8,
   parameter int IMG_W = IMG_W_DEF,
   parameter int IMG_H = IMG_H_DEF
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             enable,
   input  logic             fifo_empty,
   input  logic [WIDTH-1:0] fifo_dout,
   output logic             fifo_rd_en,
   output logic             m_valid,
   input  logic             m_ready,
   output logic [WIDTH-1:0] m_data,
   output logic             m_sof,
   output logic             m_eol,
   output logic             frame_done,
   output logic [15:0]      underrun_cnt
);

   localparam int            CW       = cnt_width(IMG_W);
   localparam int            RW       = cnt_width(IMG_H);
   localparam logic [CW-1:0] COL_LAST = CW'(IMG_W - 1);
   localparam logic [RW-1:0] ROW_LAST = RW'(IMG_H - 1);

   state_t        state;
   state_t        state_nxt;
   logic [1:0]    buf_cnt;
   logic [CW-1:0] col;
   logic [RW-1:0] row;
   logic          hs;

   // Popping looks only at the registered buffer count, never at m_ready.
   assign fifo_rd_en = (state == ST_RUN) && !fifo_empty && (buf_cnt < 2'd2);
   assign hs         = m_valid && m_ready;

   stream_skid_buf #(.WIDTH(WIDTH)) u_buf (
      .clk   (clk),
      .rst_n (rst_n),
      .push  (fifo_rd_en),
      .din   (fifo_dout),
      .ready (m_ready),
      .valid (m_valid),
      .dout  (m_data),
      .count (buf_cnt)
   );

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) state <= ST_IDLE;
      else        state <= state_nxt;
   end

   always_comb begin
      state_nxt = state;
      case (state)
         ST_IDLE:  if (enable) state_nxt = ST_RUN;
         ST_RUN:   if (!enable) state_nxt = ST_DRAIN;
         ST_DRAIN: begin
            if (enable)               state_nxt = ST_RUN;
            else if (buf_cnt == 2'd0) state_nxt = ST_IDLE;
         end
         default:  state_nxt = ST_IDLE;
      endcase
   end

   // Position survives a disable so a later RUN resumes the same frame.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         col        <= '0;
         row        <= '0;
         frame_done <= 1'b0;
      end else begin
         frame_done <= hs && (col == COL_LAST) && (row == ROW_LAST);
         if (hs) begin
            if (col == COL_LAST) begin
               col <= '0;
               row <= (row == ROW_LAST) ? '0 : row + 1'b1;
            end else begin
               col <= col + 1'b1;
            end
         end
      end
   end

   assign m_sof = m_valid && (col == '0) && (row == '0);
   assign m_eol = m_valid && (col == COL_LAST);

`ifdef FIFO_READER_UNDERRUN_CNT_EN
   logic [15:0] urun;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         urun <= 16'd0;
      end else if ((state == ST_RUN) && m_ready && (buf_cnt == 2'd0) && fifo_empty
                   && (urun != 16'hFFFF)) begin
         urun <= urun + 16'd1;
      end
   end

   assign underrun_cnt = urun;
`else
   assign underrun_cnt = 16'd0;
`endif

endmodule
